// File: rtl/link_xfr_sm.sv
// link_xfr_sm: moves complete 128-beat blocks from the link FIFO into the
// PCIe DPL buffer, tracking free DPL slots as credits and counting blocks.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for enable, a full block in the FIFO and a free slot
// AHEAD | one-cycle read-ahead strobe to the link FIFO; consumes a credit
// DATA  | streaming 128 beats, gated by the DPL stall input
// DONE  | one-cycle completion pulse; advance slot, count the block
module link_xfr_sm #(
    parameter int DPLBUF_BLKS       = 4,
    parameter int DPLBUF_SLOT_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           iLKF_FIFO_NEMPTY,
    input  logic                           iDPLBUF_BLK_RELEASE,
    input  logic                           iDPLBUF_STALL,
    input  logic                           iREG_XFR_EN,
    input  logic                           iREG_XFR_CLR,
    output logic                           oXFR_AHEAD_ST,
    output logic                           oDPLBUF_DATA_V,
    output logic [DPLBUF_SLOT_WIDTH-1:0]   oXFR_DPLBUF_SLOT,
    output logic [6:0]                     oXFR_DPLBUF_OFST,
    output logic                           oXFR_DPLBUF_DONE,
    output logic                           oXFR_BUSY,
    output logic [DPLBUF_SLOT_WIDTH:0]     oXFR_REG_CREDITS,
    output logic [31:0]                    oXFR_REG_BLKCNT,
    output logic                           oXFR_REG_CREDIT_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AHEAD = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DPLBUF_SLOT_WIDTH:0]   CREDITS_FULL = (DPLBUF_SLOT_WIDTH+1)'(DPLBUF_BLKS);
    localparam logic [DPLBUF_SLOT_WIDTH:0]   CREDIT_ONE   = (DPLBUF_SLOT_WIDTH+1)'(1);
    localparam logic [DPLBUF_SLOT_WIDTH-1:0] SLOT_ONE     = DPLBUF_SLOT_WIDTH'(1);

    state_t                         state;
    logic [6:0]                     ofst;
    logic [DPLBUF_SLOT_WIDTH-1:0]   slot;
    logic [DPLBUF_SLOT_WIDTH:0]     credits;
    logic [31:0]                    blkcnt;
    logic                           credit_err;
    logic                           ahead_st;
    logic                           done;
    logic                           busy;

    logic start;
    logic beat;
    logic take;
    logic give;

    assign start = iREG_XFR_EN & iLKF_FIFO_NEMPTY & (credits != '0);
    assign beat  = (state == DATA) & ~iDPLBUF_STALL;
    // The credit is consumed while the prefetch strobe is out.
    assign take  = (state == AHEAD);
    assign give  = iDPLBUF_BLK_RELEASE;

    // Transfer sequencing with registered strobes, beat offset and slot pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ahead_st <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ofst     <= 7'd0;
            slot     <= '0;
        end else begin
            ahead_st <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= AHEAD;
                        ahead_st <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                AHEAD: begin
                    state <= DATA;
                end
                DATA: begin
                    if (beat) begin
                        if (ofst == 7'd127) begin
                            state <= DONE;
                            done  <= 1'b1;
                            ofst  <= 7'd0;
                        end else begin
                            ofst <= ofst + 7'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ofst  <= 7'd0;
                    slot  <= slot + SLOT_ONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-slot credits; a release while already full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CREDITS_FULL;
        end else if (give & ~take) begin
            if (credits != CREDITS_FULL) begin
                credits <= credits + CREDIT_ONE;
            end
        end else if (take & ~give) begin
            credits <= credits - CREDIT_ONE;
        end
    end

    // Sticky overflow flag for releases that had no slot to return to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_err <= 1'b0;
        end else if (iREG_XFR_CLR) begin
            credit_err <= 1'b0;
        end else if (give & ~take & (credits == CREDITS_FULL)) begin
            credit_err <= 1'b1;
        end
    end

    // Saturating completed-block counter; clear wins over a same-cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blkcnt <= 32'd0;
        end else if (iREG_XFR_CLR) begin
            blkcnt <= 32'd0;
        end else if ((state == DONE) && (blkcnt != 32'hFFFF_FFFF)) begin
            blkcnt <= blkcnt + 32'd1;
        end
    end

    assign oXFR_AHEAD_ST       = ahead_st;
    assign oDPLBUF_DATA_V      = beat;
    assign oXFR_DPLBUF_SLOT    = slot;
    assign oXFR_DPLBUF_OFST    = ofst;
    assign oXFR_DPLBUF_DONE    = done;
    assign oXFR_BUSY           = busy;
    assign oXFR_REG_CREDITS    = credits;
    assign oXFR_REG_BLKCNT     = blkcnt;
    assign oXFR_REG_CREDIT_ERR = credit_err;

endmodule

// File: tb/tb_link_xfr_sm.sv
// Bench for link_xfr_sm: directed scenarios followed by random traffic, all
// checked every cycle against a block/beat counting reference model.
module tb_link_xfr_sm;

    localparam int BLKS = 4;
    localparam int SW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          nempty, rel, stall, en, clr;
    logic          ahead_st, data_v, done, busy, cerr;
    logic [SW-1:0] slot;
    logic [6:0]    ofst;
    logic [SW:0]   credits;
    logic [31:0]   blkcnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: a block is a prefetch cycle, 128 counted beats, a done cycle
    bit     m_busy, m_ahead, m_done, m_err;
    int     m_beats, m_credits, m_slot;
    longint m_blkcnt;

    int n_ahead, n_beats, n_done, last_ahead, last_done;

    link_xfr_sm #(.DPLBUF_BLKS(BLKS), .DPLBUF_SLOT_WIDTH(SW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .iLKF_FIFO_NEMPTY    (nempty),
        .iDPLBUF_BLK_RELEASE (rel),
        .iDPLBUF_STALL       (stall),
        .iREG_XFR_EN         (en),
        .iREG_XFR_CLR        (clr),
        .oXFR_AHEAD_ST       (ahead_st),
        .oDPLBUF_DATA_V      (data_v),
        .oXFR_DPLBUF_SLOT    (slot),
        .oXFR_DPLBUF_OFST    (ofst),
        .oXFR_DPLBUF_DONE    (done),
        .oXFR_BUSY           (busy),
        .oXFR_REG_CREDITS    (credits),
        .oXFR_REG_BLKCNT     (blkcnt),
        .oXFR_REG_CREDIT_ERR (cerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ahead = 0; m_done = 0; m_err = 0;
        m_beats = 0; m_credits = BLKS; m_slot = 0; m_blkcnt = 0;
    endtask

    function automatic bit in_data();
        return m_busy && !m_ahead && !m_done;
    endfunction

    // One clock cycle: inputs are already set; check at negedge, advance model.
    task automatic step();
        int     nc;
        bit     ne;
        longint nb;
        @(negedge clk);
        chk("ahead_st", ahead_st, m_ahead);
        chk("data_v",   data_v,   in_data() && !stall);
        chk("ofst",     ofst,     m_beats % 128);
        chk("done",     done,     m_done);
        chk("busy",     busy,     m_busy);
        chk("slot",     slot,     m_slot);
        chk("credits",  credits,  m_credits);
        chk("blkcnt",   blkcnt,   m_blkcnt[31:0]);
        chk("cred_err", cerr,     m_err);
        if (ahead_st) begin n_ahead++; last_ahead = cyc; end
        if (data_v)   n_beats++;
        if (done)     begin n_done++; last_done = cyc; end

        nc = m_credits + int'(rel) - int'(m_ahead);
        ne = m_err;
        if (nc > BLKS) begin nc = BLKS; ne = 1; end
        nb = m_blkcnt;
        if (m_done) begin
            if (nb < 64'hFFFF_FFFF) nb++;
            m_slot = (m_slot + 1) % BLKS;
            m_busy = 0; m_done = 0; m_beats = 0;
        end else if (m_ahead) begin
            m_ahead = 0;
        end else if (m_busy) begin
            if (!stall) m_beats++;
            if (m_beats == 128) m_done = 1;
        end else if (en && nempty && m_credits > 0) begin
            m_busy = 1; m_ahead = 1;
        end
        if (clr) begin nb = 0; ne = 0; end
        m_credits = nc; m_err = ne; m_blkcnt = nb;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_rel();
        rel = 1'b1; step(); rel = 1'b0;
    endtask

    task automatic clear_counts();
        n_ahead = 0; n_beats = 0; n_done = 0; last_ahead = -1; last_done = -1;
    endtask

    initial begin
        int  n, m, sa, sb, pre_beats;
        bit  found;

        rst_n = 1'b0; nempty = 0; rel = 0; stall = 0; en = 0; clr = 0;
        model_reset();
        clear_counts();
        #12;
        chk("rst_ahead",   ahead_st, 0);
        chk("rst_dv",      data_v,   0);
        chk("rst_done",    done,     0);
        chk("rst_busy",    busy,     0);
        chk("rst_slot",    slot,     0);
        chk("rst_ofst",    ofst,     0);
        chk("rst_credits", credits,  BLKS);
        chk("rst_blkcnt",  blkcnt,   0);
        chk("rst_err",     cerr,     0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single block, no stall
        clear_counts();
        n = cyc; en = 1; nempty = 1; step(); nempty = 0;
        run(140);
        chk("s1_ahead_at", last_ahead, n + 1);
        chk("s1_done_at",  last_done,  n + 130);
        chk("s1_beats",    n_beats,    128);
        chk("s1_ndone",    n_done,     1);
        chk("s1_slot",     slot,       1);
        chk("s1_credits",  credits,    3);
        chk("s1_blkcnt",   blkcnt,     1);
        pulse_rel(); run(2);
        chk("s1_cred_back", credits, 4);

        // stalls: 5 cycles at beat 10, 3 cycles on the last beat
        clear_counts();
        sa = 0; sb = 0;
        n = cyc; nempty = 1; step(); nempty = 0;
        for (int i = 0; i < 160; i++) begin
            stall = 0;
            if (in_data() && m_beats == 10  && sa < 5) begin stall = 1; sa++; end
            if (in_data() && m_beats == 127 && sb < 3) begin stall = 1; sb++; end
            step();
        end
        stall = 0;
        chk("s2_done_at", last_done, n + 138);
        chk("s2_beats",   n_beats,   128);
        chk("s2_blkcnt",  blkcnt,    2);
        pulse_rel(); run(2);

        // credit exhaustion from a fresh reset
        rst_n = 1'b0; #1; rst_n = 1'b1;
        model_reset();
        clear_counts();
        nempty = 1; en = 1;
        run(540);
        chk("s3_blocks",  n_ahead, 4);
        chk("s3_credits", credits, 0);
        chk("s3_busy",    busy,    0);
        chk("s3_slot",    slot,    0);
        m = cyc; pulse_rel();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (last_ahead >= m) found = 1;
        end
        chk("s3_restart_seen", found, 1);
        chk("s3_restart_at",   last_ahead, m + 2);
        nempty = 0;
        run(140);
        chk("s3_credits_end", credits, 0);

        // release coinciding with the prefetch cycle
        pulse_rel(); step(); pulse_rel(); step();
        chk("s4_credits_pre", credits, 2);
        clear_counts();
        n = cyc; nempty = 1; step(); nempty = 0;
        rel = 1; step(); rel = 0;
        step();
        chk("s4_ahead_at",   last_ahead, n + 1);
        chk("s4_credits_net", credits,   2);
        run(140);
        pulse_rel(); pulse_rel(); step();
        chk("s4_credits_full", credits, 4);
        chk("s4_err_before",   cerr,    0);
        pulse_rel(); step();
        chk("s4_err_set",     cerr,    1);
        chk("s4_credits_sat", credits, 4);
        run(20);
        chk("s4_err_sticky", cerr, 1);
        clr = 1; step(); clr = 0; step();
        chk("s4_err_clr",    cerr,   0);
        chk("s4_blkcnt_clr", blkcnt, 0);

        // enable dropped at beat 50
        clear_counts();
        nempty = 1; en = 1; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (in_data() && m_beats == 50) found = 1;
            else step();
        end
        chk("s5_reach_50", found, 1);
        en = 0;
        run(300);
        chk("s5_blocks", n_ahead, 1);
        chk("s5_beats",  n_beats, 128);
        chk("s5_done",   n_done,  1);
        chk("s5_busy",   busy,    0);

        // async reset at beat 60
        en = 1; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (in_data() && m_beats == 60) found = 1;
            else step();
        end
        chk("s6_reach_60", found, 1);
        chk("s6_pre_busy", busy,  1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_dv",      data_v,  0);
        chk("s6_busy",    busy,    0);
        chk("s6_credits", credits, 4);
        chk("s6_blkcnt",  blkcnt,  0);
        chk("s6_ofst",    ofst,    0);
        chk("s6_slot",    slot,    0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; cyc++;
        clear_counts();
        n = cyc; step(); nempty = 0;
        step();
        chk("s6_restart_at",   last_ahead, n + 1);
        chk("s6_restart_slot", slot,       0);
        chk("s6_restart_ofst", ofst,       0);
        run(140);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            nempty = ($urandom % 4) != 0;
            en     = ($urandom % 8) != 0;
            stall  = ($urandom % 5) == 0;
            rel    = ($urandom % 6) == 0;
            clr    = ($urandom % 60) == 0;
            step();
        end
        nempty = 0; rel = 0; stall = 0; clr = 0;
        run(200);
        chk("rnd_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_xfr_sm.md
# link_xfr_sm

Transfer state machine on the read side of the link FIFO. It moves complete 4 KB blocks (128 words of 256 bits) from the link FIFO into the PCIe DPL buffer. It waits until the FIFO holds a full block and the DPL buffer has a free slot, then issues one read-ahead strobe followed by 128 data-valid beats. It tracks DPL buffer slot credits and keeps a completed-block statistic for the register block.

## Interface
- DPLBUF_BLKS, 4: number of 4 KB slots in the DPL buffer; power of two, 2..16.
- DPLBUF_SLOT_WIDTH, 2: log2(DPLBUF_BLKS).
- clk  in  1  link FIFO read clock; the only clock of this block.
- rst_n  in  1  reset; asynchronous assert, active-low.
- iLKF_FIFO_NEMPTY  in  1  at least one complete block is present in the link FIFO.
- iDPLBUF_BLK_RELEASE  in  1  one-cycle pulse: PCIe has drained one slot.
- iDPLBUF_STALL  in  1  DPL buffer cannot accept a beat this cycle.
- iREG_XFR_EN  in  1  transfer enable.
- iREG_XFR_CLR  in  1  one-cycle pulse: clear statistics and the sticky error.
- oXFR_AHEAD_ST  out  1  one-cycle prefetch strobe to the link FIFO.
- oDPLBUF_DATA_V  out  1  a beat is valid on the link FIFO data output this cycle.
- oXFR_DPLBUF_SLOT  out  DPLBUF_SLOT_WIDTH  slot index of the current or next transfer.
- oXFR_DPLBUF_OFST  out  7  word offset of the current beat within its slot.
- oXFR_DPLBUF_DONE  out  1  one-cycle pulse after the last beat of a block.
- oXFR_BUSY  out  1  state is not IDLE.
- oXFR_REG_CREDITS  out  DPLBUF_SLOT_WIDTH+1  free slots.
- oXFR_REG_BLKCNT  out  32  count of completed blocks; saturates.
- oXFR_REG_CREDIT_ERR  out  1  sticky: a release arrived while credits were already full.

## Operation
States:
- IDLE → AHEAD when iREG_XFR_EN & iLKF_FIFO_NEMPTY & credits != 0.
- AHEAD (1 cycle) → DATA.
- DATA → DONE on the beat where ofst == 127 and the stall input is low.
- DONE (1 cycle) → IDLE.

Per-state behaviour:
- AHEAD:
  - oXFR_AHEAD_ST = 1.
  - Credits decrement on entry.
- DATA:
  - oDPLBUF_DATA_V = ~iDPLBUF_STALL.
  - 7-bit beat counter ofst starts at 0 and increments on each valid beat only.
  - oXFR_DPLBUF_OFST = ofst.
- DONE:
  - oXFR_DPLBUF_DONE = 1.
  - Slot pointer increments modulo DPLBUF_BLKS.
  - BLKCNT increments, holding at 0xFFFFFFFF.
  - ofst returns to 0.

Enable and stall rules:
- Deasserting iREG_XFR_EN mid-block does not abort. The block completes and the FSM then stays in IDLE.
- Stall in AHEAD has no effect. Stall only gates beats in DATA.

Credits:
- Reset value is DPLBUF_BLKS.
- iDPLBUF_BLK_RELEASE adds one.
- Release and AHEAD entry in the same cycle: net unchanged.
- Release while credits == DPLBUF_BLKS with no simultaneous AHEAD entry: credits unchanged, CREDIT_ERR set.

Clear:
- iREG_XFR_CLR zeroes BLKCNT and CREDIT_ERR.
- Clear has priority over a same-cycle increment.

## Timing
- Reset values: state IDLE; AHEAD_ST, DATA_V, DONE, BUSY, CREDIT_ERR = 0; SLOT = 0; OFST = 0; BLKCNT = 0; CREDITS = DPLBUF_BLKS.
- All outputs are registered except oDPLBUF_DATA_V, which is the registered DATA state AND ~iDPLBUF_STALL.
- Start latency:
  - Start condition true at cycle N → AHEAD_ST at N+1.
  - First DATA_V at N+2, when not stalled.
  - With no stalls, the last beat is at N+129 and DONE is at N+130.
  - Earliest next AHEAD_ST is N+132.
- CREDITS reflects the decrement in the cycle after AHEAD. It reflects a release in the cycle after the pulse.
- A release pulse that arrives during DATA can enable back-to-back blocks. A pulse in cycle M makes IDLE at M+1 eligible.
- Reset mid-transfer:
  - FSM returns to IDLE and all outputs go to their reset values immediately.
  - The link FIFO must be reset in the same event; no partial-block recovery is attempted.

## Test plan
- Single block: credits 4, NEMPTY held 1, EN 1, no stall → AHEAD_ST at N+1, 128 contiguous DATA_V beats with OFST 0..127, DONE at N+130, SLOT 0→1, CREDITS 3, BLKCNT 1.
- Stall: stall high on beats 10..14 and on the last beat for 3 cycles → exactly 128 valid beats, OFST holds during stall, DONE 8 cycles later than the no-stall case.
- Credit exhaustion: no releases, NEMPTY stuck 1 → exactly 4 blocks, SLOT wraps 3→0, FSM idles with CREDITS 0. One release pulse → 5th block starts at pulse+2.
- Simultaneous release and start: release pulse in the AHEAD-entry cycle with credits 2 → CREDITS stays 2. Release with credits 4 in IDLE → CREDIT_ERR 1 and stays set until CLR.
- Enable drop mid-block: EN to 0 at OFST 50 → block completes (128 beats, DONE), then FSM stays IDLE despite NEMPTY.
- Async reset asserted at OFST 60 → DATA_V 0, BUSY 0, CREDITS 4, BLKCNT 0 immediately. After release, a new block starts at OFST 0, SLOT 0.
